// File: rtl/unsigned_div.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, 32 RUN cycles per divide.
// Divide-by-zero bypasses the iterations and returns all-ones quotient with the dividend as remainder.
module unsigned_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;

    assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    // One restoring step: the partial remainder stays below the divisor, so WIDTH+1 bits suffice.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_next = (b_i == '0) ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == S_RUN);
        done_o = (r_state == S_DONE);
    end

    // Shifted dividend register accumulates the quotient; result registers load only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_remo <= '0;
        end else if (w_accept) begin
            r_dvd <= a_i;
            r_div <= b_i;
            r_rem <= '0;
            r_cnt <= CW'(WIDTH - 1);
            if (b_i == '0) begin
                r_quot <= '1;
                r_remo <= a_i;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            if (r_cnt == '0) begin
                r_quot <= w_dvd_nxt;
                r_remo <= w_rem_nxt;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign quot_o = r_quot;
    assign rem_o  = r_remo;

endmodule
